// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the iterative square-root unit: FSM state encoding
// and the helpers that derive internal widths from the operand width.
// No ports.
// -----------------------------------------------------------------------------
package sqrt_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } sqrt_state_e;

   // Root width: one bit per pair of radicand bits.
   function automatic int unsigned root_w(input int unsigned w);
      return w / 2;
   endfunction

   // Remainder width: final r < 2q+1 needs one bit more than the root.
   function automatic int unsigned rem_w(input int unsigned w);
      return w / 2 + 1;
   endfunction

   // Trial subtraction width: {r, 2 radicand bits} plus a sign bit.
   function automatic int unsigned trial_w(input int unsigned w);
      return w / 2 + 4;
   endfunction

   // Iteration counter width, counting W/2-1 down to 0.
   function automatic int unsigned cnt_w(input int unsigned w);
      return ($clog2(w / 2) < 1) ? 1 : $clog2(w / 2);
   endfunction

endpackage : sqrt_pkg

// File: rtl/sqrt_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_ctrl
// Sequencer for sqrt_iter: IDLE/CALC/DONE FSM with the iteration down-counter.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   init       start request, honoured only in IDLE
//   ld         load radicand / clear partials (accept edge)
//   sh         perform one subtract/shift step (CALC)
//   ldres      capture root/remainder into output registers (DONE)
//   busy       registered, high from accept until done deasserts
//   done       registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module sqrt_ctrl
   import sqrt_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic init,
   output logic ld,
   output logic sh,
   output logic ldres,
   output logic busy,
   output logic done
);

   localparam int unsigned CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2 - 1);

   sqrt_state_e     state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            z;

   assign z = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // busy stays up through the done cycle, which is spent in IDLE;
            // a back-to-back accept keeps it high without a gap.
            if (init) begin
               state_d = S_CALC;
               cnt_d   = CNT_INIT;
               busy_d  = 1'b1;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_CALC: begin
            cnt_d = z ? '0 : cnt_q - 1'b1;
            if (z) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ld    = (state_q == S_IDLE) && init;
   assign sh    = (state_q == S_CALC);
   assign ldres = (state_q == S_DONE);
   assign busy  = busy_q;
   assign done  = done_q;

endmodule : sqrt_ctrl

// File: rtl/sqrt_iter.sv
// -----------------------------------------------------------------------------
// sqrt_iter
// Iterative integer square root: result = floor(sqrt(A)), one root bit per
// clock using digit-by-digit subtract/shift. Optional remainder output
// rem = A - result^2, enabled by defining SQRT_REM_EN.
// Parameters:
//   WIDTH      operand width, even and >= 4
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   init       start request (IDLE only); A sampled on the accept edge
//   A          WIDTH-bit unsigned radicand
//   result     WIDTH/2-bit root, registered, held until next completion
//   rem        WIDTH/2+1-bit remainder, registered (SQRT_REM_EN only)
//   busy       high from accept until done deasserts
//   done       one-cycle completion pulse, result/rem valid with it
// -----------------------------------------------------------------------------
module sqrt_iter
   import sqrt_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      init,
   input  logic [WIDTH-1:0]          A,
   output logic [root_w(WIDTH)-1:0]  result,
`ifdef SQRT_REM_EN
   output logic [rem_w(WIDTH)-1:0]   rem,
`endif
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned QW = root_w(WIDTH);
   localparam int unsigned RW = rem_w(WIDTH);
   localparam int unsigned TW = trial_w(WIDTH);

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $error("sqrt_iter: WIDTH must be even and >= 4");
      end
   endgenerate

   logic ld, sh, ldres;

   sqrt_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk   (clk),
      .rst   (rst),
      .init  (init),
      .ld    (ld),
      .sh    (sh),
      .ldres (ldres),
      .busy  (busy),
      .done  (done)
   );

   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [RW-1:0]    r_q, r_d;
   logic [QW-1:0]    q_q, q_d;
   logic [QW-1:0]    result_q, result_d;
   logic [RW+1:0]    r_ext;
   logic [TW-1:0]    trial;
`ifdef SQRT_REM_EN
   logic [RW-1:0]    rem_q, rem_d;
`endif

   always_comb begin
      // r is kept non-negative between steps, so the sign of the trial
      // lives only in the extra top bit of this subtraction.
      r_ext    = {r_q, a_sh_q[WIDTH-1 -: 2]};
      trial    = {1'b0, r_ext} - {2'b00, q_q, 2'b01};
      a_sh_d   = a_sh_q;
      r_d      = r_q;
      q_d      = q_q;
      result_d = ldres ? q_q : result_q;
`ifdef SQRT_REM_EN
      rem_d    = ldres ? r_q : rem_q;
`endif
      if (ld) begin
         a_sh_d = A;
         r_d    = '0;
         q_d    = '0;
      end else if (sh) begin
         a_sh_d = {a_sh_q[WIDTH-3:0], 2'b00};
         if (!trial[TW-1]) begin
            r_d = RW'(trial);
            q_d = {q_q[QW-2:0], 1'b1};
         end else begin
            r_d = RW'(r_ext);
            q_d = {q_q[QW-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_sh_q   <= '0;
         r_q      <= '0;
         q_q      <= '0;
         result_q <= '0;
`ifdef SQRT_REM_EN
         rem_q    <= '0;
`endif
      end else begin
         a_sh_q   <= a_sh_d;
         r_q      <= r_d;
         q_q      <= q_d;
         result_q <= result_d;
`ifdef SQRT_REM_EN
         rem_q    <= rem_d;
`endif
      end
   end

   assign result = result_q;
`ifdef SQRT_REM_EN
   assign rem    = rem_q;
`endif

endmodule : sqrt_iter
